// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, per-frame configuration and received-byte outputs of uart_rx.
interface uart_rx_if #(parameter int DATA_WIDTH = 8);
  logic                  rx_in;
  logic                  par_en;
  logic                  par_typ;
  logic [5:0]            prescale;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  parity_error;
  logic                  stop_error;
  modport master (
    output rx_in, par_en, par_typ, prescale,
    input  p_data, data_valid, parity_error, stop_error
  );
  modport slave (
    input  rx_in, par_en, par_typ, prescale,
    output p_data, data_valid, parity_error, stop_error
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (start, DATA_WIDTH data LSB-first, optional parity, 1 stop).
// Define UART_RX_SYNC_EN to pass rx_in through a 2-flop synchronizer first.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  uart_rx_if.slave  bus
);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  state_e                state_q, state_d;
  logic [5:0]            edge_q, edge_d, pre_q, pre_d, half;
  logic [BW-1:0]         bit_q, bit_d;
  logic [2:0]            smp_q, smp_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, p_data_q, p_data_d;
  logic                  par_en_q, par_en_d, par_typ_q, par_typ_d, par_bad_q, par_bad_d;
  logic                  valid_q, valid_d, perr_q, perr_d, serr_q, serr_d;
  logic                  rx, wrap, dec, maj;
`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], bus.rx_in};
  assign rx = sync_q[1];
`else
  assign rx = bus.rx_in;
`endif
  assign half = {1'b0, pre_q[5:1]};
  assign wrap = edge_q == pre_q - 6'd1;
  assign dec  = edge_q == half + 6'd2;
  assign maj  = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
  always_comb begin
    smp_d    = smp_q;
    smp_d[0] = (edge_q == half - 6'd1) ? rx : smp_q[0];
    smp_d[1] = (edge_q == half)        ? rx : smp_q[1];
    smp_d[2] = (edge_q == half + 6'd1) ? rx : smp_q[2];
  end
  // The IDLE cycle that sees the line low is edge 0 of the start bit.
  always_comb begin
    state_d   = state_q;
    edge_d    = wrap ? 6'd0 : edge_q + 6'd1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    pre_d     = pre_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    par_bad_d = par_bad_q;
    p_data_d  = p_data_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    serr_d    = serr_q;
    case (state_q)
      IDLE: begin
        edge_d = 6'd0;
        if (!rx) begin
          state_d   = START;
          edge_d    = 6'd1;
          bit_d     = '0;
          pre_d     = bus.prescale;
          par_en_d  = bus.par_en;
          par_typ_d = bus.par_typ;
          par_bad_d = 1'b0;
          perr_d    = 1'b0;
          serr_d    = 1'b0;
        end
      end
      START: begin
        if (dec && maj) begin
          state_d = IDLE;
          edge_d  = 6'd0;
        end else if (wrap) state_d = DATA;
      end
      DATA: begin
        if (dec) shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
        if (wrap) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == BW'(DATA_WIDTH - 1)) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (dec) par_bad_d = maj != ((^shift_q) ^ par_typ_q);
        if (wrap) state_d = STOP;
      end
      STOP: begin
        // Leave mid-stop so a start bit right after the stop bit is caught.
        if (dec) begin
          state_d = IDLE;
          edge_d  = 6'd0;
          perr_d  = par_en_q & par_bad_q;
          serr_d  = ~maj;
          if (!(par_en_q & par_bad_q) && maj) begin
            p_data_d = shift_q;
            valid_d  = 1'b1;
          end
        end else if (wrap) begin
          state_d = IDLE;
          edge_d  = 6'd0;
        end
      end
      default: begin
        state_d = IDLE;
        edge_d  = 6'd0;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q   <= IDLE;
      edge_q    <= '0;
      bit_q     <= '0;
      smp_q     <= '0;
      shift_q   <= '0;
      pre_q     <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bad_q <= 1'b0;
      p_data_q  <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      edge_q    <= edge_d;
      bit_q     <= bit_d;
      smp_q     <= smp_d;
      shift_q   <= shift_d;
      pre_q     <= pre_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_bad_q <= par_bad_d;
      p_data_q  <= p_data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      serr_q    <= serr_d;
    end
  assign bus.p_data       = p_data_q;
  assign bus.data_valid   = valid_q;
  assign bus.parity_error = perr_q;
  assign bus.stop_error   = serr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx with hand-computed expectations.
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0, n_err = 0;
  int   vcnt = 0, wide = 0;
  logic vprev = 1'b0;
  logic snap_pre, snap_v, snap_pe, snap_se;
  logic [7:0] snap_d;
  uart_rx_if #(.DATA_WIDTH(8)) bus ();
  uart_rx #(.DATA_WIDTH(8)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.data_valid) begin
      vcnt++;
      if (vprev) wide++;
    end
    vprev = bus.data_valid;
  end
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive_bit(input logic b, input int ps);
    @(negedge clk) bus.rx_in = b;
    repeat (ps - 1) @(negedge clk);
  endtask
  // Config is scrambled after the start bit: the receiver must use the latched values.
  task automatic send(input logic [7:0] d, input logic pe, pt, pb, sb, input int ps);
    bus.par_en = pe; bus.par_typ = pt; bus.prescale = 6'(ps);
    drive_bit(1'b0, ps);
    bus.par_en = ~pe; bus.par_typ = ~pt; bus.prescale = 6'd13;
    for (int i = 0; i < 8; i++) drive_bit(d[i], ps);
    if (pe) drive_bit(pb, ps);
    @(negedge clk) bus.rx_in = sb;
    repeat (ps / 2 + 2) @(negedge clk);
    snap_pre = bus.data_valid;
    @(negedge clk);
    snap_v = bus.data_valid; snap_d = bus.p_data;
    snap_pe = bus.parity_error; snap_se = bus.stop_error;
    repeat (ps - ps / 2 - 4) @(negedge clk);
    @(negedge clk) bus.rx_in = 1'b1;
    bus.par_en = pe; bus.par_typ = pt; bus.prescale = 6'(ps);
  endtask
  task automatic frame_ok(input string tag, input logic [7:0] d, input logic pe, pt, pb, input int ps);
    int v0;
    v0 = vcnt;
    send(d, pe, pt, pb, 1'b1, ps);
    check_eq({tag, "_cnt"}, vcnt - v0, 1);
    check_eq({tag, "_early"}, snap_pre, 0);
    check_eq({tag, "_lat"}, snap_v, 1);
    check_eq({tag, "_data"}, snap_d, d);
    check_eq({tag, "_perr"}, snap_pe, 0);
    check_eq({tag, "_serr"}, snap_se, 0);
  endtask
  int ps_t [3] = '{32, 16, 8};
  logic pe_t [3] = '{1'b1, 1'b1, 1'b0};
  logic pt_t [3] = '{1'b1, 1'b0, 1'b0};
  logic pb_t [3] = '{1'b1, 1'b0, 1'b0};
  initial begin
    int v0;
    logic [7:0] c3;
    rst_n = 1'b0; bus.rx_in = 1'b1; bus.par_en = 1'b0; bus.par_typ = 1'b0; bus.prescale = 6'd16;
    repeat (3) @(negedge clk);
    check_eq("rst_data", bus.p_data, 0);
    check_eq("rst_valid", bus.data_valid, 0);
    check_eq("rst_perr", bus.parity_error, 0);
    check_eq("rst_serr", bus.stop_error, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    frame_ok("odd32", 8'hBB, 1'b1, 1'b1, 1'b1, 32);
    for (int p = 0; p < 3; p++)
      for (int m = 0; m < 3; m++)
        frame_ok($sformatf("ps%0d_pe%0d_pt%0d", ps_t[p], pe_t[m], pt_t[m]), 8'hBB, pe_t[m], pt_t[m], pb_t[m], ps_t[p]);
    frame_ok("pre5a", 8'h5A, 1'b0, 1'b0, 1'b0, 16);
    v0 = vcnt;
    send(8'hBB, 1'b1, 1'b0, 1'b1, 1'b1, 16);
    check_eq("bpar_cnt", vcnt - v0, 0);
    check_eq("bpar_perr", snap_pe, 1);
    check_eq("bpar_serr", snap_se, 0);
    check_eq("bpar_data", snap_d, 8'h5A);
    repeat (5) @(negedge clk);
    check_eq("bpar_hold", bus.parity_error, 1);
    v0 = vcnt;
    send(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8);
    check_eq("bstop_cnt", vcnt - v0, 0);
    check_eq("bstop_serr", snap_se, 1);
    check_eq("bstop_perr", snap_pe, 0);
    check_eq("bstop_data", snap_d, 8'h5A);
    repeat (20) @(negedge clk);
    frame_ok("a5", 8'hA5, 1'b0, 1'b0, 1'b0, 8);
    bus.prescale = 6'd16; bus.par_en = 1'b0;
    v0 = vcnt;
    @(negedge clk) bus.rx_in = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk) bus.rx_in = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("glitch_cnt", vcnt - v0, 0);
    check_eq("glitch_data", bus.p_data, 8'hA5);
    check_eq("glitch_perr", bus.parity_error, 0);
    check_eq("glitch_serr", bus.stop_error, 0);
    frame_ok("b2b_12", 8'h12, 1'b0, 1'b0, 1'b0, 16);
    frame_ok("b2b_34", 8'h34, 1'b0, 1'b0, 1'b0, 16);
    c3 = 8'hC3;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(c3[i], 16);
    @(negedge clk) bus.rx_in = c3[4];
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_data", bus.p_data, 0);
    check_eq("mrst_valid", bus.data_valid, 0);
    check_eq("mrst_perr", bus.parity_error, 0);
    check_eq("mrst_serr", bus.stop_error, 0);
    @(negedge clk) bus.rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    frame_ok("c3", 8'hC3, 1'b0, 1'b0, 1'b0, 16);
    repeat (5) @(negedge clk);
    check_eq("total_valid", vcnt, 15);
    check_eq("valid_width", wide, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
